// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: access size codes, FSM states and
// the alignment rule used when a request is accepted.
`timescale 1ns/1ps
package mem_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeBad  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoadWait,
    StRmw
  } state_e;

  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    unique case (size)
      SizeByte: misaligned = 1'b0;
      SizeHalf: misaligned = offset[0];
      SizeWord: misaligned = (offset != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the MEM stage and the access unit, plus the
// word-RAM port. The unit uses the slave view; the pipeline/RAM side the master view.
`timescale 1ns/1ps
interface mem_access_unit_if #(
  parameter int unsigned MEM_AW = 14
) ();
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              busy;
  logic              rdata_valid;
  logic [31:0]       rdata;
  logic              wr_done;
  logic              err;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output busy, rdata_valid, rdata, wr_done, err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  busy, rdata_valid, rdata, wr_done, err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/byte_lane_align.sv
// Little-endian lane handling: extracts and extends a load from a RAM word, and
// merges right-aligned store data into a RAM word for read-modify-write.
`timescale 1ns/1ps
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] mask;
  logic [31:0] wrep;

  always_comb begin
    lane_b    = 8'(word >> {offset, 3'b000});
    lane_h    = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    mask      = 32'hFFFF_FFFF;
    wrep      = wdata;
    unique case (size)
      SizeByte: begin
        load_data = {{24{is_signed & lane_b[7]}}, lane_b};
        mask      = 32'h0000_00FF << {offset, 3'b000};
        wrep      = {4{wdata[7:0]}};
      end
      SizeHalf: begin
        load_data = {{16{is_signed & lane_h[15]}}, lane_h};
        mask      = offset[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wrep      = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    merged = (word & ~mask) | (wrep & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a one-cycle-latency word RAM.
// Word stores write in the accept cycle; sub-word stores read-modify-write.
`timescale 1ns/1ps
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_AW = 14
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);
  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [31:0]       lane_load, lane_merged;
  size_e             req_size;
  logic              unused_addr;

  assign req_size    = size_e'(bus.req_size);
  assign unused_addr = ^bus.req_addr[31:MEM_AW+2];

  byte_lane_align u_align (
    .word      (bus.mem_rdata),
    .wdata     (wdata_q),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    off_d         = off_q;
    size_d        = size_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wr_done_d     = 1'b0;
    err_d         = 1'b0;
    mem_we        = 1'b0;
    bus.mem_addr  = bus.req_addr[MEM_AW+1:2];
    bus.mem_wdata = bus.req_wdata;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (misaligned(req_size, bus.req_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            addr_d   = bus.req_addr[MEM_AW+1:2];
            off_d    = bus.req_addr[1:0];
            size_d   = req_size;
            signed_d = bus.req_signed;
            wdata_d  = bus.req_wdata;
            if (bus.req_we && req_size == SizeWord) begin
              mem_we    = 1'b1;
              wr_done_d = 1'b1;
            end else if (bus.req_we) begin
              state_d = StRmw;
            end else begin
              state_d = StLoadWait;
            end
          end
        end
      end
      StLoadWait: begin
        bus.mem_addr  = addr_q;
        rdata_d       = lane_load;
        rdata_valid_d = 1'b1;
        state_d       = StIdle;
      end
      StRmw: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = lane_merged;
        mem_we        = 1'b1;
        wr_done_d     = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A reset edge aborts whatever write this cycle would have committed.
    if (!rst_n) mem_we = 1'b0;
  end

  assign bus.mem_we      = mem_we;
  assign bus.busy        = (state_q != StIdle);
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.err         = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      off_q         <= '0;
      size_q        <= SizeByte;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      off_q         <= off_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wr_done_q     <= wr_done_d;
      err_q         <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic checked against
// a byte-addressed memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic ram_clr;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0]  ref_mem [1024];
  logic [31:0] ram [256];

  mem_access_unit_if #(.MEM_AW(14)) bus ();

  mem_access_unit #(.MEM_AW(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_bad(input int size, input int addr);
    return size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input int addr, input int size, input logic sgn);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[addr + i];
    if (sgn && n < 4 && v[8*n-1]) begin
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_store(input int addr, input int size, input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) ref_mem[addr + i] = wdata[8*i +: 8];
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Called just after a rising edge with the unit idle; returns the same way.
  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_val;
    logic [31:0] word_addr;
    logic        bad;
    word_addr = addr >> 2;
    bad       = model_bad(int'(size), int'(addr));
    drive(we, size, sgn, addr, wdata);
    @(negedge clk);
    check("accept_busy", 32'(bus.busy), 0);
    check("accept_mem_we", 32'(bus.mem_we), 32'(!bad && we && size == 2'd2));
    if (!bad) check("accept_mem_addr", 32'(bus.mem_addr), word_addr);
    if (!bad && we && size == 2'd2) check("word_st_wdata", bus.mem_wdata, wdata);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    if (bad) begin
      check("err_pulse", 32'(bus.err), 1);
      check("err_busy", 32'(bus.busy), 0);
      check("err_mem_we", 32'(bus.mem_we), 0);
    end else if (we && size == 2'd2) begin
      model_store(int'(addr), 2, wdata);
      check("word_st_done", 32'(bus.wr_done), 1);
      check("word_st_busy", 32'(bus.busy), 0);
    end else if (we) begin
      model_store(int'(addr), int'(size), wdata);
      exp_val = model_load(int'(addr) & ~3, 2, 1'b0);
      check("rmw_busy", 32'(bus.busy), 1);
      check("rmw_mem_we", 32'(bus.mem_we), 1);
      check("rmw_addr", 32'(bus.mem_addr), word_addr);
      check("rmw_wdata", bus.mem_wdata, exp_val);
      check("rmw_done_early", 32'(bus.wr_done), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rmw_done", 32'(bus.wr_done), 1);
      check("rmw_busy_end", 32'(bus.busy), 0);
      check("rmw_we_end", 32'(bus.mem_we), 0);
    end else begin
      exp_val = model_load(int'(addr), int'(size), sgn);
      check("ld_busy", 32'(bus.busy), 1);
      check("ld_mem_we", 32'(bus.mem_we), 0);
      check("ld_valid_early", 32'(bus.rdata_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ld_valid", 32'(bus.rdata_valid), 1);
      check("ld_data", bus.rdata, exp_val);
      check("ld_busy_end", 32'(bus.busy), 0);
    end
    @(posedge clk); #1;
  endtask

  logic        s_we   [3];
  logic [1:0]  s_size [3];
  logic [31:0] s_addr [3];
  logic [31:0] s_wdata[3];

  initial begin
    logic [31:0] d1, d2, keep;
    int idx, rv_cnt, wd_cnt, we_cnt;
    logic acc;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0; ram_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rvalid", 32'(bus.rdata_valid), 0);
    check("rst_wr_done", 32'(bus.wr_done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_rdata", bus.rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ram_clr = 1'b0;

    // Word store then word load.
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("word_roundtrip", model_load(32'h10, 2, 1'b0), 32'hDEAD_BEEF);

    // Byte store into a preset word.
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    access(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA);
    check("byte_merge_model", model_load(32'h20, 2, 1'b0), 32'h11AA_3344);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Sign/zero extension.
    access(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF_7F01);
    access(1'b0, 2'd0, 1'b1, 32'h32, 32'h0);
    access(1'b0, 2'd1, 1'b0, 32'h32, 32'h0);
    access(1'b0, 2'd1, 1'b1, 32'h30, 32'h0);
    access(1'b0, 2'd0, 1'b1, 32'h31, 32'h0);

    // Misaligned and illegal size.
    access(1'b1, 2'd1, 1'b0, 32'h3, 32'h1234);
    access(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h32, 32'h0);

    // Reset in the RMW cycle aborts the write.
    keep = model_load(32'h30, 2, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 32'h31, 32'h77);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstrmw_mem_we", 32'(bus.mem_we), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstrmw_wr_done", 32'(bus.wr_done), 0);
    check("rstrmw_busy", 32'(bus.busy), 0);
    check("rstrmw_rdata", bus.rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrmw_wr_done2", 32'(bus.wr_done), 0);
    @(posedge clk); #1;
    access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    check("rstrmw_kept", model_load(32'h30, 2, 1'b0), keep);

    // Back-to-back load, byte store, load with req_valid held.
    access(1'b1, 2'd2, 1'b0, 32'h40, 32'h0102_0304);
    d1 = model_load(32'h40, 2, 1'b0);
    model_store(32'h41, 0, 32'h5A);
    d2 = model_load(32'h40, 2, 1'b0);
    s_we[0] = 1'b0; s_size[0] = 2'd2; s_addr[0] = 32'h40; s_wdata[0] = 32'h0;
    s_we[1] = 1'b1; s_size[1] = 2'd0; s_addr[1] = 32'h41; s_wdata[1] = 32'h5A;
    s_we[2] = 1'b0; s_size[2] = 2'd2; s_addr[2] = 32'h40; s_wdata[2] = 32'h0;
    idx = 0; rv_cnt = 0; wd_cnt = 0; we_cnt = 0;
    drive(s_we[0], s_size[0], 1'b0, s_addr[0], s_wdata[0]);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      acc = bus.req_valid && !bus.busy;
      if (bus.rdata_valid) begin
        rv_cnt++;
        check("b2b_rv_cycle", k, (rv_cnt == 1) ? 2 : 6);
        check("b2b_rv_data", bus.rdata, (rv_cnt == 1) ? d1 : d2);
      end
      if (bus.wr_done) begin
        wd_cnt++;
        check("b2b_wd_cycle", k, 4);
      end
      if (bus.mem_we) begin
        we_cnt++;
        check("b2b_we_cycle", k, 3);
        check("b2b_we_data", bus.mem_wdata, d2);
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) drive(s_we[idx], s_size[idx], 1'b0, s_addr[idx], s_wdata[idx]);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", idx, 3);
    check("b2b_rv_count", rv_cnt, 2);
    check("b2b_wd_count", wd_cnt, 1);
    check("b2b_we_count", we_cnt, 1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
